// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU func codes, instruction layout and issue FSM states.
// Used by alu_issue and alu_issue_scoreboard.
package alu_pkg;

   typedef enum logic [3:0] {
      F_ADD  = 4'd0,
      F_SUB  = 4'd1,
      F_AND  = 4'd2,
      F_OR   = 4'd3,
      F_XOR  = 4'd4,
      F_SLL  = 4'd5,
      F_SRL  = 4'd6,
      F_SRA  = 4'd7,
      F_SLT  = 4'd8,
      F_SLTU = 4'd9,
      F_LD   = 4'd10,
      F_ST   = 4'd11,
      F_HALT = 4'hF
   } alu_func_e;

   localparam int INSTR_W  = 24;
   localparam int FUNC_LSB = 20;
   localparam int RD_LSB   = 16;
   localparam int RS1_LSB  = 12;
   localparam int RS2_LSB  = 8;
   localparam int ADDR_LSB = 0;

   typedef struct packed {
      logic [3:0] func;
      logic [3:0] rd;
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic [7:0] addr;
   } instr_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_RUN,
      S_DONE
   } state_e;

   function automatic instr_t decode(input logic [INSTR_W-1:0] w);
      instr_t d;
      d.func = w[FUNC_LSB +: 4];
      d.rd   = w[RD_LSB   +: 4];
      d.rs1  = w[RS1_LSB  +: 4];
      d.rs2  = w[RS2_LSB  +: 4];
      d.addr = w[ADDR_LSB +: 8];
      return d;
   endfunction

endpackage

// File: rtl/alu_issue_scoreboard.sv
// alu_issue_scoreboard: last HAZ_DEPTH issue slots {valid, rd} and the
// RAW comparator against the pending instruction's rs1/rs2.
module alu_issue_scoreboard #(
   parameter int HAZ_DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       shift,
   input  logic       in_valid,
   input  logic [3:0] in_rd,
   input  logic [3:0] rs1,
   input  logic [3:0] rs2,
   output logic       hazard
);

   logic [HAZ_DEPTH-1:0] vld;
   logic [3:0]           rdq [HAZ_DEPTH];

   // slot history: shifts once per RUN cycle, bubbles enter as invalid
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         vld <= '0;
         for (int i = 0; i < HAZ_DEPTH; i++)
            rdq[i] <= '0;
      end else if (shift) begin
         vld[0] <= in_valid;
         rdq[0] <= in_rd;
         for (int i = 1; i < HAZ_DEPTH; i++) begin
            vld[i] <= vld[i-1];
            rdq[i] <= rdq[i-1];
         end
      end
   end

   // any live producer writing a register the pending word reads
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HAZ_DEPTH; i++)
         if (vld[i] && (rdq[i] == rs1 || rdq[i] == rs2))
            hazard = 1'b1;
   end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: program store + issue FSM feeding the 4-stage ALU pipe.
// Define ALU_ISSUE_HAZARD_EN to build the RAW scoreboard interlock.
module alu_issue
   import alu_pkg::*;
#(
   parameter int IMEM_AW   = 6,
   parameter int HAZ_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_we,
   input  logic [IMEM_AW-1:0] load_addr,
   input  logic [23:0]        load_data,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               issue_valid,
   output logic [3:0]         rs1,
   output logic [3:0]         rs2,
   output logic [3:0]         rd,
   output logic [3:0]         func,
   output logic [7:0]         addr,
   output logic [15:0]        stall_cnt
);

   logic [23:0]        imem [2**IMEM_AW];
   state_e             state;
   state_e             state_nx;
   logic [IMEM_AW-1:0] pc;
   instr_t             ir;
   logic               hazard;
   logic               can_cmd;
   logic               do_start;
   logic               do_fill;
   logic               do_issue;
   logic               do_bubble;
   logic               in_run;

`ifdef ALU_ISSUE_HAZARD_EN
   alu_issue_scoreboard #(
      .HAZ_DEPTH (HAZ_DEPTH)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .clr      (do_start),
      .shift    (in_run),
      .in_valid (do_issue),
      .in_rd    (ir.rd),
      .rs1      (ir.rs1),
      .rs2      (ir.rs2),
      .hazard   (hazard)
   );
`else
   // no interlock: software spaces dependent words
   assign hazard = 1'b0 & (HAZ_DEPTH == 0);
`endif

   // next state and per-cycle action strobes
   always_comb begin
      state_nx  = state;
      do_start  = 1'b0;
      do_fill   = 1'b0;
      do_issue  = 1'b0;
      do_bubble = 1'b0;
      can_cmd   = 1'b0;
      in_run    = 1'b0;
      unique case (state)
         S_IDLE, S_DONE: begin
            can_cmd = 1'b1;
            if (start) begin
               do_start = 1'b1;
               state_nx = S_FILL;
            end
         end
         S_FILL: begin
            do_fill  = 1'b1;
            state_nx = S_RUN;
         end
         S_RUN: begin
            in_run = 1'b1;
            if (ir.func == F_HALT)
               state_nx = S_DONE;
            else if (hazard)
               do_bubble = 1'b1;
            else
               do_issue = 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy = (state == S_FILL) || (state == S_RUN);
   assign done = (state == S_DONE);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // program store, writable only while stopped; kept across rst
   always_ff @(posedge clk) begin
      if (!rst && load_we && can_cmd)
         imem[load_addr] <= load_data;
   end

   // pc, ir, issued fields and bubble counter
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= '0;
         ir          <= '0;
         issue_valid <= 1'b0;
         func        <= '0;
         rd          <= '0;
         rs1         <= '0;
         rs2         <= '0;
         addr        <= '0;
         stall_cnt   <= '0;
      end else begin
         issue_valid <= do_issue;
         func        <= do_issue ? ir.func : 4'd0;
         rd          <= do_issue ? ir.rd   : 4'd0;
         rs1         <= do_issue ? ir.rs1  : 4'd0;
         rs2         <= do_issue ? ir.rs2  : 4'd0;
         addr        <= do_issue ? ir.addr : 8'd0;
         if (do_start) begin
            pc        <= '0;
            stall_cnt <= '0;
         end
         if (do_fill || do_issue) begin
            ir <= decode(imem[pc]);
            pc <= pc + 1'b1;
         end
         if (do_bubble && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule
